video_timing_engine: RTL and testbench

Runtime-reconfigurable, parametrised successor to the fixed-mode video timing path. It generates pixel and line counters, DE, HSYNC and VSYNC from a timing set written through a register port. A committed timing set is applied only at a frame boundary, and the output is muted for a programmable number of frames after every switch. It also owns the frame counter, the lag-target flash cadence and the `starttrigger` pulse consumed by the lag measurement logic. It sits between the config decoder and the pixel generators (`textgen` and `videogen`).

---
 rtl/video_timing_engine.sv | 194 +++++++++++++++++++
 tb/tb_video_timing_engine.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_engine.sv
// Runtime-reconfigurable video timing generator: pixel/line counters, DE and syncs from a
// shadowed timing set swapped in at frame boundaries, plus switch muting and lag-flash cadence.
module video_timing_engine #(
  parameter int CW           = 12,
  parameter int BLANK_FRAMES = 2,
  parameter int FLASH_FRAMES = 30,
  // Timing set loaded on reset; defaults are the legacy 640x480 mode
  parameter logic [CW-1:0] RST_HVIS = CW'(640),
  parameter logic [CW-1:0] RST_HFP  = CW'(16),
  parameter logic [CW-1:0] RST_HSW  = CW'(96),
  parameter logic [CW-1:0] RST_HBP  = CW'(48),
  parameter logic [CW-1:0] RST_VVIS = CW'(480),
  parameter logic [CW-1:0] RST_VFP  = CW'(10),
  parameter logic [CW-1:0] RST_VSW  = CW'(2),
  parameter logic [CW-1:0] RST_VBP  = CW'(33),
  parameter logic [1:0]    RST_POL  = 2'b00
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  input  logic          cfg_commit,
  output logic          cfg_pending,
  output logic          cfg_error,
  output logic [CW-1:0] counterX,
  output logic [CW-1:0] counterY,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start,
  output logic          mute,
  output logic          flash,
  output logic          starttrigger,
  output logic [15:0]   frame_count
);

  localparam int TW = CW + 2;
  localparam int MW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam int PW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [8*CW-1:0] RST_SET =
    {RST_VBP, RST_VSW, RST_VFP, RST_VVIS, RST_HBP, RST_HSW, RST_HFP, RST_HVIS};

  logic [CW-1:0] shadow_q [8];
  logic [CW-1:0] shadow_d [8];
  logic [CW-1:0] active_q [8];
  logic [CW-1:0] active_d [8];
  logic [1:0]    spol_q, spol_d, apol_q, apol_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          pending_q, pending_d, error_q, error_d;
  logic [MW-1:0] muteCnt_q, muteCnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          flash_q, flash_d;
  logic [15:0]   frameCnt_q, frameCnt_d;

  logic [TW-1:0] hTot, vTot, shHTot, shVTot;
  logic [TW-1:0] hSyncStart, hSyncEnd, vSyncStart, vSyncEnd, xWide, yWide;
  logic          lineEnd, frameEnd, commitOk, firstPixel, inHSync, inVSync;

  always_comb begin
    shadow_d = shadow_q;
    spol_d   = spol_q;
    if (cfg_we) begin
      if (cfg_addr < 4'd8) begin
        shadow_d[cfg_addr[2:0]] = cfg_wdata;
      end else if (cfg_addr == 4'd8) begin
        spol_d = cfg_wdata[1:0];
      end
    end
  end

  assign hTot   = {2'b00, active_q[0]} + {2'b00, active_q[1]} + {2'b00, active_q[2]} + {2'b00, active_q[3]};
  assign vTot   = {2'b00, active_q[4]} + {2'b00, active_q[5]} + {2'b00, active_q[6]} + {2'b00, active_q[7]};
  assign shHTot = {2'b00, shadow_d[0]} + {2'b00, shadow_d[1]} + {2'b00, shadow_d[2]} + {2'b00, shadow_d[3]};
  assign shVTot = {2'b00, shadow_d[4]} + {2'b00, shadow_d[5]} + {2'b00, shadow_d[6]} + {2'b00, shadow_d[7]};

  // Validation sees the shadow including a write landing on the same cycle as the commit
  assign commitOk = (shadow_d[0] != '0) && (shadow_d[2] != '0) && (shadow_d[4] != '0) &&
                    (shadow_d[6] != '0) && (shHTot >= TW'(4)) && (shVTot >= TW'(2));

  assign xWide      = {2'b00, x_q};
  assign yWide      = {2'b00, y_q};
  assign lineEnd    = (xWide == hTot - TW'(1));
  assign frameEnd   = lineEnd && (yWide == vTot - TW'(1));
  assign firstPixel = (x_q == '0) && (y_q == '0);
  assign hSyncStart = {2'b00, active_q[0]} + {2'b00, active_q[1]};
  assign hSyncEnd   = hSyncStart + {2'b00, active_q[2]};
  assign vSyncStart = {2'b00, active_q[4]} + {2'b00, active_q[5]};
  assign vSyncEnd   = vSyncStart + {2'b00, active_q[6]};
  assign inHSync    = (xWide >= hSyncStart) && (xWide < hSyncEnd);
  assign inVSync    = (yWide >= vSyncStart) && (yWide < vSyncEnd);

  always_comb begin
    x_d        = x_q + CW'(1);
    y_d        = y_q;
    active_d   = active_q;
    apol_d     = apol_q;
    pending_d  = pending_q;
    muteCnt_d  = muteCnt_q;
    flash_d    = flash_q;
    phase_d    = phase_q;
    frameCnt_d = frameCnt_q;
    error_d    = cfg_commit && !commitOk;
    if (lineEnd) begin
      x_d = '0;
      y_d = frameEnd ? '0 : y_q + CW'(1);
    end
    if (frameEnd) begin
      frameCnt_d = frameCnt_q + 16'd1;
      if (pending_q) begin
        active_d  = shadow_d;
        apol_d    = spol_d;
        pending_d = 1'b0;
        muteCnt_d = MW'(BLANK_FRAMES);
        flash_d   = 1'b0;
        phase_d   = '0;
      end else begin
        if (muteCnt_q != '0) muteCnt_d = muteCnt_q - MW'(1);
        if (phase_q == PW'(FLASH_FRAMES - 1)) begin
          flash_d = ~flash_q;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
    end
    // A commit on the boundary cycle itself arms the following boundary
    if (cfg_commit && commitOk) pending_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= RST_SET[i*CW +: CW];
        active_q[i] <= RST_SET[i*CW +: CW];
      end
      spol_q     <= RST_POL;
      apol_q     <= RST_POL;
      x_q        <= '0;
      y_q        <= '0;
      pending_q  <= 1'b0;
      error_q    <= 1'b0;
      muteCnt_q  <= '0;
      flash_q    <= 1'b0;
      phase_q    <= '0;
      frameCnt_q <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      spol_q     <= spol_d;
      apol_q     <= apol_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pending_q  <= pending_d;
      error_q    <= error_d;
      muteCnt_q  <= muteCnt_d;
      flash_q    <= flash_d;
      phase_q    <= phase_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  // Output stage: every pin is decoded from the same x/y so they stay mutually aligned.
  // Only the first frame of each flash-on half-period fires a lag measurement.
  always_ff @(posedge clock) begin
    if (reset) begin
      counterX     <= '0;
      counterY     <= '0;
      de           <= 1'b0;
      hsync        <= ~RST_POL[0];
      vsync        <= ~RST_POL[1];
      frame_start  <= 1'b0;
      mute         <= 1'b0;
      flash        <= 1'b0;
      starttrigger <= 1'b0;
      frame_count  <= '0;
    end else begin
      counterX     <= x_q;
      counterY     <= y_q;
      de           <= (x_q < active_q[0]) && (y_q < active_q[4]);
      hsync        <= inHSync ? apol_q[0] : ~apol_q[0];
      vsync        <= inVSync ? apol_q[1] : ~apol_q[1];
      frame_start  <= firstPixel;
      mute         <= (muteCnt_q != '0);
      flash        <= flash_q;
      starttrigger <= firstPixel && flash_q && (phase_q == '0) && (muteCnt_q == '0);
      frame_count  <= frameCnt_q;
    end
  end

  assign cfg_pending = pending_q;
  assign cfg_error   = error_q;

endmodule

// File: tb/tb_video_timing_engine.sv
// Bench for video_timing_engine: a default-mode instance checked from a vector table and a
// small-mode instance checked every cycle against a frame-position reference model.
module tb_video_timing_engine;

  localparam int CW    = 12;
  localparam int BLANK = 2;
  localparam int FLASH = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          dReset, dWe, dCommit, dPending, dError;
  logic [3:0]    dAddr;
  logic [CW-1:0] dWdata, dX, dY;
  logic          dDe, dHsync, dVsync, dFs, dMute, dFlash, dSt;
  logic [15:0]   dFc;

  logic          mReset, mWe, mCommit, mPending, mError;
  logic [3:0]    mAddr;
  logic [CW-1:0] mWdata, mX, mY;
  logic          mDe, mHsync, mVsync, mFs, mMute, mFlash, mSt;
  logic [15:0]   mFc;

  video_timing_engine dutDefault (
    .clock(clock), .reset(dReset), .cfg_we(dWe), .cfg_addr(dAddr), .cfg_wdata(dWdata),
    .cfg_commit(dCommit), .cfg_pending(dPending), .cfg_error(dError), .counterX(dX),
    .counterY(dY), .de(dDe), .hsync(dHsync), .vsync(dVsync), .frame_start(dFs),
    .mute(dMute), .flash(dFlash), .starttrigger(dSt), .frame_count(dFc)
  );

  video_timing_engine #(
    .CW(CW), .BLANK_FRAMES(BLANK), .FLASH_FRAMES(FLASH),
    .RST_HVIS(12'd6), .RST_HFP(12'd2), .RST_HSW(12'd2), .RST_HBP(12'd2),
    .RST_VVIS(12'd4), .RST_VFP(12'd1), .RST_VSW(12'd1), .RST_VBP(12'd2), .RST_POL(2'b00)
  ) dutMain (
    .clock(clock), .reset(mReset), .cfg_we(mWe), .cfg_addr(mAddr), .cfg_wdata(mWdata),
    .cfg_commit(mCommit), .cfg_pending(mPending), .cfg_error(mError), .counterX(mX),
    .counterY(mY), .de(mDe), .hsync(mHsync), .vsync(mVsync), .frame_start(mFs),
    .mute(mMute), .flash(mFlash), .starttrigger(mSt), .frame_count(mFc)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: frame position as a linear cycle index plus frame-level bookkeeping
  int act[8], shd[8];
  int actPol, shdPol, muteCnt, phase, frames, pos;
  bit pend, flashOn;
  int cyclesInFrame = 0;
  int lastFrameLen = 0;

  typedef struct {int x; int y; bit de; bit hs; bit vs; bit fs; bit mu; bit fl; bit st; int fc;} outs_t;

  task automatic modelReset();
    act = '{6, 2, 2, 2, 4, 1, 1, 2};
    shd = act;
    actPol = 0; shdPol = 0; muteCnt = 0; phase = 0; frames = 0; pos = 0;
    pend = 0; flashOn = 0;
  endtask

  function automatic outs_t modelOut();
    outs_t o;
    int ht = act[0] + act[1] + act[2] + act[3];
    o.x  = pos % ht;
    o.y  = pos / ht;
    o.de = (o.x < act[0]) && (o.y < act[4]);
    o.hs = ((o.x >= act[0] + act[1]) && (o.x < act[0] + act[1] + act[2])) == ((actPol & 1) != 0);
    o.vs = ((o.y >= act[4] + act[5]) && (o.y < act[4] + act[5] + act[6])) == ((actPol & 2) != 0);
    o.fs = (pos == 0);
    o.mu = (muteCnt != 0);
    o.fl = flashOn;
    o.st = (pos == 0) && flashOn && (phase == 0) && (muteCnt == 0);
    o.fc = frames;
    return o;
  endfunction

  task automatic modelAdvance(input bit we, input int addr, input int data, input bit commit,
                              output bit err);
    int ht, vt;
    bit valid;
    if (we && addr < 8) shd[addr] = data;
    if (we && addr == 8) shdPol = data & 3;
    valid = (shd[0] != 0) && (shd[2] != 0) && (shd[4] != 0) && (shd[6] != 0) &&
            (shd[0] + shd[1] + shd[2] + shd[3] >= 4) && (shd[4] + shd[5] + shd[6] + shd[7] >= 2);
    err = commit && !valid;
    ht = act[0] + act[1] + act[2] + act[3];
    vt = act[4] + act[5] + act[6] + act[7];
    if (pos == ht * vt - 1) begin
      frames = (frames + 1) % 65536;
      if (pend) begin
        act = shd; actPol = shdPol; pend = 0;
        muteCnt = BLANK; flashOn = 0; phase = 0;
      end else begin
        if (muteCnt > 0) muteCnt--;
        phase++;
        if (phase == FLASH) begin
          phase = 0;
          flashOn = !flashOn;
        end
      end
      pos = 0;
    end else begin
      pos++;
    end
    if (commit && valid) pend = 1;
  endtask

  task automatic tick();
    outs_t e;
    bit rstS, weS, commitS, expErr;
    int addrS, dataS;
    e = modelOut();
    rstS = mReset; weS = mWe; commitS = mCommit; addrS = int'(mAddr); dataS = int'(mWdata);
    @(posedge clock);
    if (rstS) begin
      modelReset();
      e = '{0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      expErr = 0;
    end else begin
      modelAdvance(weS, addrS, dataS, commitS, expErr);
    end
    #1;
    checkOutput("model", {mX, mY, mDe, mHsync, mVsync, mFs, mMute, mFlash, mSt, mFc, mPending, mError},
                {12'(e.x), 12'(e.y), e.de, e.hs, e.vs, e.fs, e.mu, e.fl, e.st, 16'(e.fc), pend, expErr});
    if (rstS) cyclesInFrame = 0;
    else if (mFs) begin lastFrameLen = cyclesInFrame; cyclesInFrame = 1; end
    else cyclesInFrame++;
  endtask

  task automatic applyStimulus(input bit we, input int addr, input int data, input bit commit);
    mWe = we; mAddr = 4'(addr); mWdata = 12'(data); mCommit = commit;
    tick();
    mWe = 1'b0; mCommit = 1'b0;
  endtask

  task automatic waitFrameStart(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!mFs && n < budget);
    checkOutput("frame_start reached", mFs, 1);
  endtask

  typedef struct {int cyc; int x; int y; bit de; bit hs; bit vs; bit fs;} defVec_t;
  defVec_t defVecs[$];

  task automatic defTick();
    @(posedge clock);
    #1;
  endtask

  task automatic runDefaultTable(input int maxCyc);
    int idx = 0;
    int deCnt = 0;
    int hsLow = 0;
    for (int c = 0; c <= maxCyc; c++) begin
      defTick();
      if (c < 800) begin
        deCnt += int'(dDe);
        hsLow += int'(!dHsync);
      end
      while (idx < defVecs.size() && defVecs[idx].cyc == c) begin
        checkOutput($sformatf("default vector cycle %0d", c), {dX, dY, dDe, dHsync, dVsync, dFs},
                    {12'(defVecs[idx].x), 12'(defVecs[idx].y), defVecs[idx].de,
                     defVecs[idx].hs, defVecs[idx].vs, defVecs[idx].fs});
        idx++;
      end
    end
    checkOutput("default de per line", deCnt, 640);
    checkOutput("default hsync low per line", hsLow, 96);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int stCount, prevSt, firstSt, n;
    dReset = 1'b1; dWe = 1'b0; dAddr = '0; dWdata = '0; dCommit = 1'b0;
    mReset = 1'b1; mWe = 1'b0; mAddr = '0; mWdata = '0; mCommit = 1'b0;
    modelReset();

    defVecs.push_back('{0,    0,   0, 1'b1, 1'b1, 1'b1, 1'b1});
    defVecs.push_back('{639,  639, 0, 1'b1, 1'b1, 1'b1, 1'b0});
    defVecs.push_back('{640,  640, 0, 1'b0, 1'b1, 1'b1, 1'b0});
    defVecs.push_back('{655,  655, 0, 1'b0, 1'b1, 1'b1, 1'b0});
    defVecs.push_back('{656,  656, 0, 1'b0, 1'b0, 1'b1, 1'b0});
    defVecs.push_back('{751,  751, 0, 1'b0, 1'b0, 1'b1, 1'b0});
    defVecs.push_back('{752,  752, 0, 1'b0, 1'b1, 1'b1, 1'b0});
    defVecs.push_back('{799,  799, 0, 1'b0, 1'b1, 1'b1, 1'b0});
    defVecs.push_back('{800,  0,   1, 1'b1, 1'b1, 1'b1, 1'b0});
    defVecs.push_back('{1700, 100, 2, 1'b1, 1'b1, 1'b1, 1'b0});

    defTick();
    defTick();
    checkOutput("default reset outputs", {dX, dY, dDe, dHsync, dVsync, dFs, dMute, dFlash, dSt, dFc, dPending, dError},
                {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0});
    dReset = 1'b0;
    runDefaultTable(1700);

    // Commit a new mode mid-frame, then reset before it can apply
    dWe = 1'b1; dAddr = 4'd0; dWdata = 12'd320;
    defTick();
    dWe = 1'b0; dCommit = 1'b1;
    defTick();
    dCommit = 1'b0;
    checkOutput("default pending after commit", dPending, 1);
    dReset = 1'b1;
    defTick();
    checkOutput("default mid-frame reset", {dX, dY, dDe, dHsync, dVsync, dFs, dMute, dFlash, dSt, dFc, dPending},
                {12'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0});
    dReset = 1'b0;
    runDefaultTable(800);

    // Randomised traffic on the small instance against the model
    tick();
    mReset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      int r, a, d;
      r = $urandom_range(0, 19);
      a = $urandom_range(0, 10);
      if (a == 8) d = $urandom_range(0, 3);
      else if (a % 2 == 1) d = $urandom_range(0, 6);
      else d = $urandom_range(1, 6);
      mWe = (r < 3); mAddr = 4'(a); mWdata = 12'(d); mCommit = (r == 5);
      tick();
    end
    mWe = 1'b0; mCommit = 1'b0;

    // Small mode committed mid-frame
    mReset = 1'b1;
    tick();
    mReset = 1'b0;
    tick();
    checkOutput("first frame_start after reset", mFs, 1);
    repeat (20) tick();
    applyStimulus(1, 0, 4, 0); applyStimulus(1, 1, 1, 0); applyStimulus(1, 2, 1, 0);
    applyStimulus(1, 3, 2, 0); applyStimulus(1, 4, 2, 0); applyStimulus(1, 5, 1, 0);
    applyStimulus(1, 6, 1, 0); applyStimulus(1, 7, 1, 0); applyStimulus(1, 8, 3, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("pending after valid commit", mPending, 1);
    waitFrameStart(200);
    checkOutput("old frame length", lastFrameLen, 96);
    checkOutput("pending cleared after switch", mPending, 0);
    checkOutput("mute first frame", mMute, 1);
    repeat (4) tick();
    checkOutput("hsync idle at x=4", {mX, mHsync}, {12'd4, 1'b0});
    tick();
    checkOutput("hsync active at x=5", {mX, mHsync}, {12'd5, 1'b1});
    waitFrameStart(100);
    checkOutput("small frame length", lastFrameLen, 40);
    checkOutput("mute second frame", mMute, 1);
    waitFrameStart(100);
    checkOutput("mute cleared third frame", mMute, 0);

    // Rejected commit
    applyStimulus(1, 2, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("cfg_error pulse", mError, 1);
    checkOutput("pending after rejected commit", mPending, 0);
    tick();
    checkOutput("cfg_error single cycle", mError, 0);
    for (int f = 0; f < 3; f++) begin
      waitFrameStart(100);
      checkOutput("frame length after reject", lastFrameLen, 40);
    end
    applyStimulus(1, 2, 1, 0);

    // Flash cadence
    stCount = 0;
    prevSt = -1;
    for (int f = 0; f < 16; f++) begin
      waitFrameStart(100);
      if (mSt) begin
        checkOutput("starttrigger with de", mDe, 1);
        if (prevSt >= 0) checkOutput("starttrigger spacing", f - prevSt, 4);
        prevSt = f;
        stCount++;
      end
    end
    checkOutput("starttrigger count in 16 frames", stCount, 4);

    // Switch while flash is on
    n = 0;
    do begin
      waitFrameStart(100);
      n++;
    end while (!mFlash && n < 8);
    checkOutput("flash on before switch", mFlash, 1);
    applyStimulus(0, 0, 0, 1);
    waitFrameStart(100);
    checkOutput("switch forces flash off and mute", {mFlash, mMute, mSt}, {1'b0, 1'b1, 1'b0});
    firstSt = -1;
    for (int f = 1; f < 6; f++) begin
      waitFrameStart(100);
      if (mSt && firstSt < 0) firstSt = f;
    end
    checkOutput("first starttrigger frame after switch", firstSt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
